// File: rtl/mips_mdu_pkg.sv
// Shared types for the MIPS multiply/divide unit: operation codes and FSM states.
package mips_mdu_pkg;

   typedef enum logic [2:0] {
      MULT  = 3'd0,
      MULTU = 3'd1,
      DIV   = 3'd2,
      DIVU  = 3'd3,
      MTHI  = 3'd4,
      MTLO  = 3'd5
   } mdu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } mdu_state_t;

endpackage

// File: rtl/mips_mdu_condneg.sv
// Conditional two's-complement negate: y = neg ? -a : a (modular).
module condneg #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic             neg,
   output logic [WIDTH-1:0] y
);

   assign y = neg ? (~a + WIDTH'(1)) : a;

endmodule

// File: rtl/mips_mdu.sv
// Serial radix-2 multiply/divide unit with HI/LO registers for the MIPS datapath.
// Magnitudes are processed unsigned; signs are re-applied in the single FIX cycle.
module mips_mdu
   import mips_mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  mdu_op_t          op,
   input  logic             flush,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   mdu_state_t           r_state;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH:0]       r_rem;     // multiply: upper product half; divide: partial remainder
   logic [WIDTH-1:0]     r_q;       // multiply: multiplier/low half; divide: dividend/quotient
   logic [WIDTH-1:0]     r_m;       // multiplicand or divisor magnitude
   logic                 r_is_div;
   logic                 r_neg_lo;
   logic                 r_neg_hi;
   logic                 r_busy;
   logic                 r_done;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   logic                 w_signed;
   logic                 w_op_div;
   logic [WIDTH-1:0]     w_abs_a;
   logic [WIDTH-1:0]     w_abs_b;
   logic [WIDTH:0]       w_madd;
   logic [WIDTH:0]       w_rsh;
   logic [WIDTH:0]       w_trial;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quo;
   logic [WIDTH-1:0]     w_rem;

   assign w_signed = (op == MULT) || (op == DIV);
   assign w_op_div = (op == DIV) || (op == DIVU);

   condneg #(.WIDTH(WIDTH)) u_abs_a (.a(srca), .neg(w_signed & srca[WIDTH-1]), .y(w_abs_a));
   condneg #(.WIDTH(WIDTH)) u_abs_b (.a(srcb), .neg(w_signed & srcb[WIDTH-1]), .y(w_abs_b));

   condneg #(.WIDTH(2*WIDTH)) u_fix_p (.a({r_rem[WIDTH-1:0], r_q}), .neg(r_neg_lo), .y(w_prod));
   condneg #(.WIDTH(WIDTH))   u_fix_q (.a(r_q), .neg(r_neg_lo), .y(w_quo));
   condneg #(.WIDTH(WIDTH))   u_fix_r (.a(r_rem[WIDTH-1:0]), .neg(r_neg_hi), .y(w_rem));

   assign w_madd  = r_rem + {1'b0, (r_q[0] ? r_m : '0)};
   assign w_rsh   = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
   assign w_trial = w_rsh - {1'b0, r_m};

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_q      <= '0;
         r_m      <= '0;
         r_is_div <= 1'b0;
         r_neg_lo <= 1'b0;
         r_neg_hi <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         r_done <= 1'b0;
         if (flush) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (start) begin
                     case (op)
                        MTHI: r_hi <= srca;
                        MTLO: r_lo <= srca;
                        MULT, MULTU, DIV, DIVU: begin
                           r_q      <= w_abs_a;
                           r_m      <= w_abs_b;
                           r_rem    <= '0;
                           r_is_div <= w_op_div;
                           // Divide by zero keeps the all-ones quotient unsigned.
                           r_neg_lo <= w_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1])
                                       & ~(w_op_div & (srcb == '0));
                           r_neg_hi <= w_signed & srca[WIDTH-1];
                           r_cnt    <= '0;
                           r_busy   <= 1'b1;
                           r_state  <= RUN;
                        end
                        default: ;
                     endcase
                  end
               end
               RUN: begin
                  if (r_is_div) begin
                     if (!w_trial[WIDTH]) begin
                        r_rem <= w_trial;
                        r_q   <= {r_q[WIDTH-2:0], 1'b1};
                     end else begin
                        r_rem <= w_rsh;
                        r_q   <= {r_q[WIDTH-2:0], 1'b0};
                     end
                  end else begin
                     r_rem <= {1'b0, w_madd[WIDTH:1]};
                     r_q   <= {w_madd[0], r_q[WIDTH-1:1]};
                  end
                  if (r_cnt == CW'(WIDTH-1)) begin
                     r_cnt   <= '0;
                     r_state <= FIX;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               FIX: begin
                  if (r_is_div) begin
                     r_lo <= w_quo;
                     r_hi <= w_rem;
                  end else begin
                     {r_hi, r_lo} <= w_prod;
                  end
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mips_mdu.sv
// Directed bench for mips_mdu: arithmetic reference model checked every cycle plus literal expectations.
module tb_mips_mdu;
   import mips_mdu_pkg::*;

   localparam int W = 32;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          flush = 1'b0;
   mdu_op_t       op    = MULT;
   logic [W-1:0]  srca  = '0;
   logic [W-1:0]  srcb  = '0;
   logic          busy;
   logic          done;
   logic [W-1:0]  hi;
   logic [W-1:0]  lo;

   int total = 0;
   int bad   = 0;

   // Reference model state
   logic          m_busy = 1'b0;
   logic          m_done = 1'b0;
   logic [W-1:0]  m_hi   = '0;
   logic [W-1:0]  m_lo   = '0;
   logic [W-1:0]  p_hi   = '0;
   logic [W-1:0]  p_lo   = '0;
   int            m_left = 0;

   mips_mdu #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (rst_n),
      .start (start),
      .op    (op),
      .flush (flush),
      .srca  (srca),
      .srcb  (srcb),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Result of a MULT/MULTU/DIV/DIVU straight from MIPS arithmetic rules.
   function automatic void model_result(input mdu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b,
                                        output logic [W-1:0] h, output logic [W-1:0] l);
      longint          sa, sb, sp, sq, sr;
      longint unsigned up;
      logic [63:0]     v;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h = '0;
      l = '0;
      case (o)
         MULT: begin
            sp = sa * sb;
            v  = sp;
            h  = v[63:32];
            l  = v[31:0];
         end
         MULTU: begin
            up = longint'(a) * longint'(b);
            v  = up;
            h  = v[63:32];
            l  = v[31:0];
         end
         DIV: begin
            if (b == '0) begin
               l = '1;
               h = a;
            end else begin
               sq = sa / sb;
               sr = sa % sb;
               v  = sq;
               l  = v[31:0];
               v  = sr;
               h  = v[31:0];
            end
         end
         DIVU: begin
            if (b == '0) begin
               l = '1;
               h = a;
            end else begin
               l = a / b;
               h = a % b;
            end
         end
         default: ;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0;
         m_done = 1'b0;
         m_hi   = '0;
         m_lo   = '0;
         m_left = 0;
      end else begin
         m_done = 1'b0;
         if (flush) begin
            m_busy = 1'b0;
            m_left = 0;
         end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_hi   = p_hi;
               m_lo   = p_lo;
            end
         end else if (start) begin
            case (op)
               MTHI: m_hi = srca;
               MTLO: m_lo = srca;
               MULT, MULTU, DIV, DIVU: begin
                  model_result(op, srca, srcb, p_hi, p_lo);
                  m_busy = 1'b1;
                  m_left = W + 1;
               end
               default: ;
            endcase
         end
      end
   end

   always @(negedge clk) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("hi",   64'(hi),   64'(m_hi));
      check("lo",   64'(lo),   64'(m_lo));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input mdu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1;
      op    = o;
      srca  = a;
      srcb  = b;
      cyc();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n, output int nb);
      n  = 0;
      nb = 0;
      while (!done && n < 100) begin
         if (busy) nb++;
         cyc();
         n++;
      end
   endtask

   task automatic run_check(input string name, input mdu_op_t o, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
      int n, nb;
      issue(o, a, b);
      wait_done(n, nb);
      check({name, "_latency"}, 64'(n), 64'(W + 1));
      check({name, "_hi"}, 64'(hi), 64'(eh));
      check({name, "_lo"}, 64'(lo), 64'(el));
   endtask

   initial begin
      int n, nb, dn;
      #1 rst_n = 1'b0;
      repeat (2) cyc();
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      rst_n = 1'b1;
      cyc();

      // MULT -3 x 5 with exact latency and busy length
      issue(MULT, 32'hFFFF_FFFD, 32'h0000_0005);
      wait_done(n, nb);
      check("mult_latency", 64'(n), 64'd33);
      check("mult_busy_cycles", 64'(nb), 64'd33);
      check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
      check("mult_lo", 64'(lo), 64'hFFFF_FFF1);
      cyc();
      check("done_one_cycle", 64'(done), 64'd0);

      run_check("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

      issue(MTLO, 32'h1234_5678, 32'h0);
      check("mtlo_lo", 64'(lo), 64'h1234_5678);
      check("mtlo_hi", 64'(hi), 64'hFFFF_FFFE);
      check("mtlo_done", 64'(done), 64'd0);
      check("mtlo_busy", 64'(busy), 64'd0);

      run_check("mult_pos_neg", MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_check("div_neg7_2", DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_check("div_7_neg2", DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      run_check("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run_check("divu_zero", DIVU, 32'h0000_0064, 32'h0, 32'h0000_0064, 32'hFFFF_FFFF);
      run_check("div_neg_zero", DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

      // Requests while busy are ignored
      issue(DIVU, 32'd100, 32'd7);
      repeat (4) cyc();
      start = 1'b1; op = MULT; srca = 32'd3; srcb = 32'd3;
      cyc();
      op = MTHI; srca = 32'hDEAD_BEEF;
      cyc();
      start = 1'b0;
      wait_done(n, nb);
      check("busy_ignore_lo", 64'(lo), 64'h0000_000E);
      check("busy_ignore_hi", 64'(hi), 64'h0000_0002);
      cyc();

      // Flush mid-run: no done, hi/lo untouched
      issue(DIVU, 32'd1000, 32'd3);
      repeat (9) cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      check("flush_busy", 64'(busy), 64'd0);
      dn = 0;
      repeat (40) begin
         if (done) dn++;
         cyc();
      end
      check("flush_no_done", 64'(dn), 64'd0);
      check("flush_hi", 64'(hi), 64'h0000_0002);
      check("flush_lo", 64'(lo), 64'h0000_000E);

      // Flush wins over a simultaneous MTHI
      start = 1'b1; op = MTHI; srca = 32'hDEAD_BEEF; flush = 1'b1;
      cyc();
      start = 1'b0; flush = 1'b0;
      check("flush_mthi_hi", 64'(hi), 64'h0000_0002);

      // Unknown op encoding is ignored
      start = 1'b1; op = mdu_op_t'(3'd7); srca = 32'h5555_5555;
      cyc();
      start = 1'b0;
      check("bad_op_busy", 64'(busy), 64'd0);
      check("bad_op_hi", 64'(hi), 64'h0000_0002);

      // Flush landing on the FIX cycle suppresses the write
      issue(MULTU, 32'd5, 32'd5);
      repeat (W) cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      check("fixflush_done", 64'(done), 64'd0);
      check("fixflush_lo", 64'(lo), 64'h0000_000E);
      cyc();

      // Asynchronous reset mid-operation
      issue(MULT, 32'd6, 32'd7);
      repeat (11) cyc();
      check("pre_rst_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_done", 64'(done), 64'd0);
      check("async_rst_hi", 64'(hi), 64'd0);
      check("async_rst_lo", 64'(lo), 64'd0);
      repeat (2) cyc();
      rst_n = 1'b1;
      cyc();
      run_check("mult_after_rst", MULT, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A);

      repeat (2) cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
